// File: rtl/i2c_master_pkg.sv
// Shared constants for the I2C master sequencer.
// State codes, register bit positions and quarter-phase codes.
package i2c_master_pkg;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_START     = 4'd1;
    localparam logic [3:0] S_ADDR      = 4'd2;
    localparam logic [3:0] S_ADDR_ACK  = 4'd3;
    localparam logic [3:0] S_WRITE     = 4'd4;
    localparam logic [3:0] S_WRITE_ACK = 4'd5;
    localparam logic [3:0] S_READ      = 4'd6;
    localparam logic [3:0] S_READ_ACK  = 4'd7;
    localparam logic [3:0] S_STOP      = 4'd8;

    localparam int CMD_GO      = 7;
    localparam int CMD_CNT_MSB = 3;
    localparam int CMD_CNT_LSB = 0;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_NACK = 2;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick source: one tick every period+1 clocks.
// load restarts the count; freeze holds it and suppresses ticks.
module i2c_tick_gen
    import i2c_master_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       freeze,
    input  logic [7:0] period,
    output logic       tick
);

    logic [7:0] count;

    assign tick = !freeze && (count == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (load) begin
            count <= period;
        end else if (!freeze) begin
            count <= tick ? period : count - 8'd1;
        end
    end

endmodule

// File: rtl/i2c_master_sequencer.sv
// Byte-level I2C master: START, address, data bytes via FIFOs, STOP.
// Bus timing is four prescaled quarter ticks per bit.
module i2c_master_sequencer
    import i2c_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  pclk_i,
    input  logic                  preset_ni,
    input  logic [7:0]            reg_command_i,
    input  logic [7:0]            reg_slave_address_i,
    input  logic [7:0]            reg_prescale_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_empty_i,
    output logic                  tx_rd_en_o,
    input  logic                  rx_full_i,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_wr_en_o,
    input  logic                  sda_i,
    output logic                  sda_o,
    output logic                  scl_o,
    output logic [7:0]            status_o
);

    logic [3:0]            state;
    logic [1:0]            q;
    logic [2:0]            bit_cnt;
    logic [3:0]            byte_cnt;
    logic [3:0]            n_last;
    logic [DATA_WIDTH-1:0] shift;
    logic [7:0]            addr_lat;
    logic [7:0]            p_lat;
    logic                  go_q;
    logic                  done;
    logic                  nack;
    logic                  ack_in;
    logic                  pend;

    logic       go;
    logic       start;
    logic       tick;
    logic       bit_end;
    logic       last_bit;
    logic       last_byte;
    logic       stall;
    logic       wr_next;
    logic       scl_hi;
    logic [7:0] period;

    logic [ADDR_WIDTH-1:0] unused_aw;
    logic [2:0]            unused_cmd;

    assign unused_aw  = '0;
    assign unused_cmd = reg_command_i[6:4];

    assign go        = reg_command_i[CMD_GO];
    assign start     = (state == S_IDLE) && go && !go_q;
    assign bit_end   = tick && (q == Q3) && (state != S_IDLE);
    assign last_bit  = (bit_cnt == 3'd7);
    assign last_byte = (byte_cnt == n_last);
    assign scl_hi    = (q == Q1) || (q == Q2);
    assign period    = start ? reg_prescale_i : p_lat;

    // A pending RX byte holds q0 (SCL low) until the FIFO has room.
    assign stall = (state == S_READ_ACK) && (q == Q0)
                && pend && rx_full_i;
    assign rx_wr_en_o = (state == S_READ_ACK) && (q == Q0)
                     && pend && !rx_full_i;

    assign wr_next = bit_end && !ack_in && !tx_empty_i
                  && ((state == S_WRITE_ACK)
                   || (state == S_ADDR_ACK && !addr_lat[0]));
    assign tx_rd_en_o = wr_next;

    i2c_tick_gen u_tick (
        .clk    (pclk_i),
        .rst_n  (preset_ni),
        .load   (start),
        .freeze (stall),
        .period (period),
        .tick   (tick)
    );

    always_comb begin
        status_o          = '0;
        status_o[ST_BUSY] = (state != S_IDLE);
        status_o[ST_DONE] = done;
        status_o[ST_NACK] = nack;
    end

    always_comb begin
        scl_o = 1'b1;
        sda_o = 1'b1;
        unique case (state)
            S_START: begin
                scl_o = (q != Q3);
                sda_o = (q == Q0) || (q == Q1);
            end
            S_STOP: begin
                scl_o = (q != Q0);
                sda_o = (q == Q2) || (q == Q3);
            end
            S_ADDR, S_WRITE: begin
                scl_o = scl_hi;
                sda_o = shift[DATA_WIDTH-1];
            end
            S_READ_ACK: begin
                scl_o = scl_hi;
                sda_o = last_byte;
            end
            S_ADDR_ACK, S_WRITE_ACK, S_READ: begin
                scl_o = scl_hi;
                sda_o = 1'b1;
            end
            default: begin
                scl_o = 1'b1;
                sda_o = 1'b1;
            end
        endcase
    end

    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            state     <= S_IDLE;
            q         <= Q0;
            bit_cnt   <= 3'd0;
            byte_cnt  <= 4'd0;
            n_last    <= 4'd0;
            shift     <= '0;
            addr_lat  <= 8'd0;
            p_lat     <= 8'd0;
            go_q      <= 1'b0;
            done      <= 1'b0;
            nack      <= 1'b0;
            ack_in    <= 1'b1;
            pend      <= 1'b0;
            rx_data_o <= '0;
        end else begin
            go_q <= go;
            if (rx_wr_en_o) begin
                pend <= 1'b0;
            end
            if (start) begin
                state    <= S_START;
                q        <= Q0;
                addr_lat <= reg_slave_address_i;
                p_lat    <= reg_prescale_i;
                n_last   <= reg_command_i[CMD_CNT_MSB:CMD_CNT_LSB];
                done     <= 1'b0;
                nack     <= 1'b0;
            end else if (tick && state != S_IDLE) begin
                q <= q + 2'd1;
                if (q == Q2) begin
                    ack_in <= sda_i;
                    if (state == S_READ) begin
                        shift <= {shift[DATA_WIDTH-2:0], sda_i};
                    end
                end
            end
            if (bit_end) begin
                unique case (state)
                    S_START: begin
                        state   <= S_ADDR;
                        shift   <= addr_lat;
                        bit_cnt <= 3'd0;
                    end
                    S_ADDR, S_WRITE: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        shift   <= {shift[DATA_WIDTH-2:0], 1'b0};
                        if (last_bit) begin
                            state <= (state == S_ADDR)
                                   ? S_ADDR_ACK : S_WRITE_ACK;
                        end
                    end
                    S_ADDR_ACK: begin
                        if (ack_in) begin
                            nack  <= 1'b1;
                            state <= S_STOP;
                        end else if (addr_lat[0]) begin
                            state    <= S_READ;
                            byte_cnt <= 4'd0;
                            bit_cnt  <= 3'd0;
                        end else if (tx_empty_i) begin
                            state <= S_STOP;
                        end else begin
                            state   <= S_WRITE;
                            shift   <= tx_data_i;
                            bit_cnt <= 3'd0;
                        end
                    end
                    S_WRITE_ACK: begin
                        if (ack_in) begin
                            nack  <= 1'b1;
                            state <= S_STOP;
                        end else if (tx_empty_i) begin
                            state <= S_STOP;
                        end else begin
                            state   <= S_WRITE;
                            shift   <= tx_data_i;
                            bit_cnt <= 3'd0;
                        end
                    end
                    S_READ: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            state     <= S_READ_ACK;
                            rx_data_o <= shift;
                            pend      <= 1'b1;
                        end
                    end
                    S_READ_ACK: begin
                        if (last_byte) begin
                            state <= S_STOP;
                        end else begin
                            state    <= S_READ;
                            byte_cnt <= byte_cnt + 4'd1;
                            bit_cnt  <= 3'd0;
                        end
                    end
                    S_STOP: begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_sequencer.sv
// Bench for i2c_master_sequencer: bus-level model of each transaction,
// checked cycle by cycle, plus literal pins on lengths and data.
module tb_i2c_master_sequencer;

    typedef struct packed {
        logic       scl;
        logic       sda;
        logic       slv;
        logic       full;
        logic       push;
        logic [7:0] pd;
        logic       nk;
    } exp_t;

    logic       clk = 1'b0;
    logic       preset_ni;
    logic [7:0] reg_command_i;
    logic [7:0] reg_slave_address_i;
    logic [7:0] reg_prescale_i;
    logic [7:0] tx_data_i;
    logic       tx_empty_i;
    logic       tx_rd_en_o;
    logic       rx_full_i;
    logic [7:0] rx_data_o;
    logic       rx_wr_en_o;
    logic       sda_i;
    logic       sda_o;
    logic       scl_o;
    logic [7:0] status_o;
    logic       slv;

    logic [7:0] txmem [16];
    logic [7:0] rx_got [16];
    int tx_rp = 0;
    int tx_wp = 0;
    int pops = 0;
    int rx_n = 0;

    int passed = 0;
    int total = 0;

    exp_t mq[$];
    int   hi_runs[$];
    int   pp;
    logic nk_m;

    always #5 clk = ~clk;

    // Open-drain bus: either side can pull SDA low.
    assign sda_i      = sda_o & slv;
    assign tx_empty_i = (tx_rp == tx_wp);
    assign tx_data_i  = txmem[tx_rp[3:0]];

    always @(posedge clk) begin
        if (tx_rd_en_o) begin
            tx_rp <= tx_rp + 1;
            pops  <= pops + 1;
        end
        if (rx_wr_en_o) begin
            rx_got[rx_n[3:0]] <= rx_data_o;
            rx_n <= rx_n + 1;
        end
    end

    i2c_master_sequencer dut (
        .pclk_i              (clk),
        .preset_ni           (preset_ni),
        .reg_command_i       (reg_command_i),
        .reg_slave_address_i (reg_slave_address_i),
        .reg_prescale_i      (reg_prescale_i),
        .tx_data_i           (tx_data_i),
        .tx_empty_i          (tx_empty_i),
        .tx_rd_en_o          (tx_rd_en_o),
        .rx_full_i           (rx_full_i),
        .rx_data_o           (rx_data_o),
        .rx_wr_en_o          (rx_wr_en_o),
        .sda_i               (sda_i),
        .sda_o               (sda_o),
        .scl_o               (scl_o),
        .status_o            (status_o)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s: got %0h want %0h at %0t",
                      nm, act, want, $time);
    endtask

    task automatic push_tx(input logic [7:0] v);
        txmem[tx_wp % 16] = v;
        tx_wp++;
    endtask

    function automatic void putn(input logic c, input logic d,
                                 input logic s, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e = '0;
            e.scl = c;
            e.sda = d;
            e.slv = s;
            e.nk = nk_m;
            mq.push_back(e);
        end
    endfunction

    function automatic void put(input logic c, input logic d,
                                input logic s);
        putn(c, d, s, pp);
    endfunction

    // One bit: m is what the master drives, s what the slave drives.
    function automatic void bitq(input logic m, input logic s);
        put(1'b0, m, s);
        put(1'b1, m, s);
        put(1'b1, m, s);
        put(1'b0, m, s);
    endfunction

    function automatic void mbyte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) bitq(b[i], 1'b1);
    endfunction

    function automatic void sbyte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) bitq(1'b1, b[i]);
    endfunction

    function automatic void rack(input logic m, input logic [7:0] d,
                                 input int st);
        exp_t e;
        for (int i = 0; i < st; i++) begin
            e = '0;
            e.sda = m;
            e.slv = 1'b1;
            e.full = 1'b1;
            e.nk = nk_m;
            mq.push_back(e);
        end
        e = '0;
        e.sda = m;
        e.slv = 1'b1;
        e.push = 1'b1;
        e.pd = d;
        e.nk = nk_m;
        mq.push_back(e);
        putn(1'b0, m, 1'b1, pp - 1);
        put(1'b1, m, 1'b1);
        put(1'b1, m, 1'b1);
        put(1'b0, m, 1'b1);
    endfunction

    function automatic void build(
        input logic [7:0]  ab,
        input int          p,
        input logic        aack,
        input int          nwr,
        input logic [31:0] wdp,
        input int          wnak,
        input int          nrd,
        input logic [31:0] rdp,
        input int          st_at,
        input int          st_n
    );
        mq.delete();
        pp = p + 1;
        nk_m = 1'b0;
        put(1'b1, 1'b1, 1'b1);
        put(1'b1, 1'b1, 1'b1);
        put(1'b1, 1'b0, 1'b1);
        put(1'b0, 1'b0, 1'b1);
        mbyte(ab);
        bitq(1'b1, aack);
        if (aack) begin
            nk_m = 1'b1;
        end else if (ab[0]) begin
            for (int i = 0; i < nrd; i++) begin
                sbyte(rdp[8*i +: 8]);
                rack(i == nrd - 1, rdp[8*i +: 8],
                     (i == st_at) ? st_n : 0);
            end
        end else begin
            for (int j = 0; j < nwr; j++) begin
                mbyte(wdp[8*j +: 8]);
                bitq(1'b1, j == wnak);
                if (j == wnak) begin
                    nk_m = 1'b1;
                    break;
                end
            end
        end
        put(1'b0, 1'b0, 1'b1);
        put(1'b1, 1'b0, 1'b1);
        put(1'b1, 1'b1, 1'b1);
        put(1'b1, 1'b1, 1'b1);
    endfunction

    task automatic run_txn(input logic [7:0] cmd, input logic [7:0] ab,
                           input logic [7:0] p, input bit hold,
                           input int abort_at);
        exp_t e;
        int   run;
        hi_runs.delete();
        run = 0;
        @(negedge clk);
        reg_command_i = 8'h00;
        @(negedge clk);
        reg_command_i = cmd;
        reg_slave_address_i = ab;
        reg_prescale_i = p;
        for (int k = 0; k < mq.size(); k++) begin
            e = mq[k];
            @(negedge clk);
            slv = e.slv;
            rx_full_i = e.full;
            if (k == 5) begin
                reg_command_i = hold ? 8'h8F : 8'h0F;
                reg_slave_address_i = ~ab;
                reg_prescale_i = p + 8'd2;
            end
            #1;
            chk("scl", 32'(scl_o), 32'(e.scl));
            chk("sda", 32'(sda_o), 32'(e.sda));
            chk("busy", 32'(status_o[0]), 32'd1);
            chk("done", 32'(status_o[1]), 32'd0);
            chk("nack", 32'(status_o[2]), 32'(e.nk));
            chk("rx_wr_en", 32'(rx_wr_en_o), 32'(e.push));
            if (e.push) chk("rx_data", 32'(rx_data_o), 32'(e.pd));
            if (scl_o) begin
                run++;
            end else if (run > 0) begin
                hi_runs.push_back(run);
                run = 0;
            end
            if (k == abort_at) begin
                #2 preset_ni = 1'b0;
                #1;
                chk("rst_scl", 32'(scl_o), 32'd1);
                chk("rst_sda", 32'(sda_o), 32'd1);
                chk("rst_status", 32'(status_o), 32'd0);
                slv = 1'b1;
                rx_full_i = 1'b0;
                reg_command_i = 8'h00;
                @(negedge clk);
                preset_ni = 1'b1;
                return;
            end
        end
        @(negedge clk);
        slv = 1'b1;
        rx_full_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("idle_scl", 32'(scl_o), 32'd1);
            chk("idle_sda", 32'(sda_o), 32'd1);
            chk("status_end", 32'(status_o),
                32'({5'b0, nk_m, 2'b10}));
            @(negedge clk);
        end
        reg_command_i = 8'h00;
    endtask

    initial begin
        int p0;
        int r0;
        preset_ni = 1'b0;
        reg_command_i = 8'h00;
        reg_slave_address_i = 8'h00;
        reg_prescale_i = 8'h00;
        rx_full_i = 1'b0;
        slv = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_scl", 32'(scl_o), 32'd1);
        chk("reset_sda", 32'(sda_o), 32'd1);
        chk("reset_status", 32'(status_o), 32'd0);
        chk("reset_tx_rd", 32'(tx_rd_en_o), 32'd0);
        chk("reset_rx_wr", 32'(rx_wr_en_o), 32'd0);
        chk("reset_rx_data", 32'(rx_data_o), 32'd0);
        @(negedge clk);
        preset_ni = 1'b1;

        // Write 0xA5 to 0x50, go held high afterwards.
        push_tx(8'hA5);
        build(8'hA0, 0, 1'b0, 1, 32'hA5, -1, 0, 32'h0, -1, 0);
        chk("len_wr", 32'(mq.size()), 32'd80);
        p0 = pops;
        run_txn(8'h80, 8'hA0, 8'd0, 1'b1, -1);
        chk("pops_wr", 32'(pops - p0), 32'd1);

        // Address NACK: no pop.
        push_tx(8'h3C);
        build(8'hA0, 0, 1'b1, 1, 32'h3C, -1, 0, 32'h0, -1, 0);
        chk("len_anak", 32'(mq.size()), 32'd44);
        p0 = pops;
        run_txn(8'h80, 8'hA0, 8'd0, 1'b0, -1);
        chk("pops_anak", 32'(pops - p0), 32'd0);
        tx_wp = tx_rp;

        // Read three bytes.
        build(8'hA1, 0, 1'b0, 0, 32'h0, -1, 3, 32'h332211, -1, 0);
        chk("len_rd3", 32'(mq.size()), 32'd152);
        r0 = rx_n;
        run_txn(8'h82, 8'hA1, 8'd0, 1'b0, -1);
        chk("rx_cnt", 32'(rx_n - r0), 32'd3);
        chk("rx0", 32'(rx_got[(r0 + 0) % 16]), 32'h11);
        chk("rx1", 32'(rx_got[(r0 + 1) % 16]), 32'h22);
        chk("rx2", 32'(rx_got[(r0 + 2) % 16]), 32'h33);

        // Read three with RX FIFO full for 20 clocks at byte 2.
        build(8'hA1, 0, 1'b0, 0, 32'h0, -1, 3, 32'h332211, 1, 20);
        chk("len_stall", 32'(mq.size()), 32'd172);
        r0 = rx_n;
        run_txn(8'h82, 8'hA1, 8'd0, 1'b0, -1);
        chk("rx_cnt_st", 32'(rx_n - r0), 32'd3);
        chk("rx1_st", 32'(rx_got[(r0 + 1) % 16]), 32'h22);
        chk("rx2_st", 32'(rx_got[(r0 + 2) % 16]), 32'h33);

        // Prescale 3, one-byte write.
        push_tx(8'h5A);
        build(8'h78, 3, 1'b0, 1, 32'h5A, -1, 0, 32'h0, -1, 0);
        chk("len_p3", 32'(mq.size()), 32'd320);
        p0 = pops;
        run_txn(8'h80, 8'h78, 8'd3, 1'b0, -1);
        chk("pops_p3", 32'(pops - p0), 32'd1);
        chk("scl_high_p3", 32'(hi_runs[1]), 32'd8);

        // Reset in the middle of the first data byte.
        push_tx(8'h96);
        push_tx(8'h69);
        build(8'hA0, 1, 1'b0, 2, 32'h6996, -1, 0, 32'h0, -1, 0);
        p0 = pops;
        run_txn(8'h80, 8'hA0, 8'd1, 1'b0, 100);
        chk("pops_abort", 32'(pops - p0), 32'd1);
        #1;
        chk("post_rst_status", 32'(status_o), 32'd0);
        tx_wp = tx_rp;

        // Fresh transaction: slave NACKs the first data byte.
        push_tx(8'hC3);
        push_tx(8'h3C);
        build(8'hA0, 0, 1'b0, 2, 32'h3CC3, 0, 0, 32'h0, -1, 0);
        chk("len_dnak", 32'(mq.size()), 32'd80);
        p0 = pops;
        run_txn(8'h80, 8'hA0, 8'd0, 1'b0, -1);
        chk("pops_dnak", 32'(pops - p0), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
